// File: rtl/key_press_classifier.sv
// Classifies a debounced active-low key into short / double / long press pulses.
// Define KEY_REPEAT_EN to make Long_Pulse auto-repeat every REPEAT_CYC while held.
module key_press_classifier #(
  parameter int LONG_CYC   = 50000000,
  parameter int DBL_CYC    = 15000000,
  parameter int REPEAT_CYC = 10000000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic Key_In,
  output logic Short_Pulse,
  output logic Double_Pulse,
  output logic Long_Pulse,
  output logic Busy
);

  localparam int MAX_AB = (LONG_CYC > DBL_CYC) ? LONG_CYC : DBL_CYC;
  localparam int MAX_C  = (MAX_AB > REPEAT_CYC) ? MAX_AB : REPEAT_CYC;
  localparam int CW     = $clog2(MAX_C) + 1;

  // The sample that moves IDLE->PRESS1 (and PRESS1->WAIT2) is already the first
  // counted sample, so the terminal count sits one below the usual N-1.
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 2);
  localparam logic [CW-1:0] DBL_LAST  = CW'(DBL_CYC - 2);
`ifdef KEY_REPEAT_EN
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYC - 1);
`endif

  typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, PRESS2, HOLD} state_t;

  state_t          state, state_nxt;
  logic            k_r, arm;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            short_nxt, dbl_nxt, long_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    short_nxt = 1'b0;
    dbl_nxt   = 1'b0;
    long_nxt  = 1'b0;
    case (state)
      IDLE:   if (arm && !k_r) state_nxt = PRESS1;
      PRESS1: begin
        if (k_r) state_nxt = WAIT2;
        else if (cnt == LONG_LAST) begin
          state_nxt = HOLD;
          long_nxt  = 1'b1;
        end else cnt_nxt = cnt + 1'b1;
      end
      // A press arriving on the timeout cycle takes priority over the short pulse.
      WAIT2: begin
        if (!k_r) state_nxt = PRESS2;
        else if (cnt == DBL_LAST) begin
          state_nxt = IDLE;
          short_nxt = 1'b1;
        end else cnt_nxt = cnt + 1'b1;
      end
      PRESS2: begin
        if (k_r) begin
          state_nxt = IDLE;
          dbl_nxt   = 1'b1;
        end
      end
      HOLD: begin
        if (k_r) state_nxt = IDLE;
`ifdef KEY_REPEAT_EN
        else if (cnt == REP_LAST) begin
          long_nxt = 1'b1;
          cnt_nxt  = '0;
        end else cnt_nxt = cnt + 1'b1;
`endif
      end
      default: state_nxt = IDLE;
    endcase
    if (state_nxt != state) cnt_nxt = '0;
  end

  // arm follows the real input, not k_r's reset value, so a key held
  // through reset must be released before it can start a gesture.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      k_r          <= 1'b1;
      arm          <= 1'b0;
      state        <= IDLE;
      cnt          <= '0;
      Short_Pulse  <= 1'b0;
      Double_Pulse <= 1'b0;
      Long_Pulse   <= 1'b0;
      Busy         <= 1'b0;
    end else begin
      k_r          <= Key_In;
      arm          <= arm | Key_In;
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      Short_Pulse  <= short_nxt;
      Double_Pulse <= dbl_nxt;
      Long_Pulse   <= long_nxt;
      Busy         <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_key_press_classifier.sv
// Randomized + directed bench for key_press_classifier against a sample-counting gesture model.
module tb_key_press_classifier;
  localparam int LONG_CYC   = 20;
  localparam int DBL_CYC    = 8;
  localparam int REPEAT_CYC = 5;

  logic CLK = 1'b0, RST_N = 1'b0, Key_In = 1'b1;
  logic Short_Pulse, Double_Pulse, Long_Pulse, Busy;

  int n_cmp = 0, n_bad = 0;

  key_press_classifier #(.LONG_CYC(LONG_CYC), .DBL_CYC(DBL_CYC), .REPEAT_CYC(REPEAT_CYC)) dut (
    .CLK(CLK), .RST_N(RST_N), .Key_In(Key_In),
    .Short_Pulse(Short_Pulse), .Double_Pulse(Double_Pulse),
    .Long_Pulse(Long_Pulse), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  // gesture model: ph 0=idle 1=first press 2=release gap 3=second press 4=held long
  int   ph, low_n, gap_n, rep_n;
  bit   armed;
  logic m_kr;
  logic e_s, e_d, e_l, e_b;
  int   cyc, n_s, n_d, n_l, last_s, last_d, rel;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_step(input logic key, input logic rst);
    e_s = 1'b0; e_d = 1'b0; e_l = 1'b0;
    if (!rst) begin
      ph = 0; armed = 1'b0; m_kr = 1'b1; low_n = 0; gap_n = 0; rep_n = 0;
    end else begin
      case (ph)
        0: if (armed && !m_kr) begin ph = 1; low_n = 1; end
        1: begin
          if (!m_kr) begin
            low_n++;
            if (low_n == LONG_CYC) begin e_l = 1'b1; ph = 4; rep_n = 0; end
          end else begin
            ph = 2; gap_n = 1;
          end
        end
        2: begin
          if (!m_kr) ph = 3;
          else begin
            gap_n++;
            if (gap_n == DBL_CYC) begin e_s = 1'b1; ph = 0; end
          end
        end
        3: if (m_kr) begin e_d = 1'b1; ph = 0; end
        default: begin
          if (m_kr) ph = 0;
`ifdef KEY_REPEAT_EN
          else begin
            rep_n++;
            if (rep_n == REPEAT_CYC) begin e_l = 1'b1; rep_n = 0; end
          end
`endif
        end
      endcase
      armed = armed | key;
      m_kr  = key;
    end
    e_b = (ph != 0);
  endtask

  task automatic tick(input logic key, input logic rst);
    @(negedge CLK);
    Key_In = key;
    RST_N  = rst;
    @(posedge CLK);
    model_step(key, rst);
    cyc++;
    #1;
    chk("short", Short_Pulse, e_s);
    chk("double", Double_Pulse, e_d);
    chk("long", Long_Pulse, e_l);
    chk("busy", Busy, e_b);
    if (Short_Pulse)  begin n_s++; last_s = cyc; end
    if (Double_Pulse) begin n_d++; last_d = cyc; end
    if (Long_Pulse)   n_l++;
  endtask

  task automatic seg(input logic key, input int n);
    repeat (n) tick(key, 1'b1);
  endtask

  task automatic clr();
    n_s = 0; n_d = 0; n_l = 0; last_s = -1000; last_d = -1000;
  endtask

  initial begin
    logic key;
    ph = 0; armed = 1'b0; m_kr = 1'b1; low_n = 0; gap_n = 0; rep_n = 0; cyc = 0;
    clr();
    repeat (3) tick(1'b1, 1'b0);
    seg(1'b1, 3);

    // short press, latency from release
    clr(); seg(1'b0, 5); rel = cyc + 1; seg(1'b1, 12);
    chk("t1_short_n", n_s, 1);
    chk("t1_other_n", n_d + n_l, 0);
    chk("t1_short_lat", last_s - rel, DBL_CYC);

    // double press
    clr(); seg(1'b0, 4); seg(1'b1, 3); seg(1'b0, 4); rel = cyc + 1; seg(1'b1, 12);
    chk("t2_double_n", n_d, 1);
    chk("t2_short_n", n_s, 0);
    chk("t2_double_lat", last_d - rel, 1);

    // long threshold boundary
    clr(); seg(1'b0, LONG_CYC - 1); seg(1'b1, 12);
    chk("t3a_long_n", n_l, 0);
    chk("t3a_short_n", n_s, 1);
    clr(); seg(1'b0, LONG_CYC); seg(1'b1, 12);
    chk("t3b_long_n", n_l, 1);
    chk("t3b_other_n", n_s + n_d, 0);

    // long hold, repeat behaviour
    clr(); seg(1'b0, 40); seg(1'b1, 12);
`ifdef KEY_REPEAT_EN
    chk("t4_long_n", n_l, 5);
`else
    chk("t4_long_n", n_l, 1);
`endif

    // reset mid-press with key held through it
    clr(); seg(1'b0, 11); tick(1'b0, 1'b0); seg(1'b0, 30);
    chk("t5_held_pulses", n_s + n_d + n_l, 0);
    seg(1'b1, 3);
    clr(); seg(1'b0, 5); seg(1'b1, 12);
    chk("t5_short_n", n_s, 1);

    // second press landing on the last gap cycle wins over the timeout
    clr(); seg(1'b0, 4); seg(1'b1, DBL_CYC - 1); seg(1'b0, 3); seg(1'b1, 12);
    chk("t6_double_n", n_d, 1);
    chk("t6_short_n", n_s, 0);
    // one cycle later it is a separate gesture
    clr(); seg(1'b0, 4); seg(1'b1, DBL_CYC); seg(1'b0, 3); seg(1'b1, 12);
    chk("t6b_short_n", n_s, 2);
    chk("t6b_double_n", n_d, 0);

    // random gestures with occasional resets
    key = 1'b0;
    for (int i = 0; i < 80; i++) begin
      seg(key, $urandom_range(1, 26));
      if ($urandom_range(0, 19) == 0) tick(key, 1'b0);
      key = ~key;
    end
    seg(1'b1, 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
